// File: rtl/id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// id_ex_operand_stage
//
// Purpose: ID/EX pipeline register. It resolves EX/MEM and MEM/WB forwarding
// for rs and rt, then selects the two ALU operands: A is either the
// forwarded rs or the zero-extended shift amount, and B is either the
// forwarded rt or the immediate. It registers A, B, the 6-bit ALU function
// code, the destination and the write-enable for the execute stage. For
// shifts, alu_b carries the value to shift and alu_a[4:0] the shift amount.
// Stall holds the stage and flush inserts a bubble. A saturating counter
// records the number of bubbles caused by flush, for debug.
//
// Handshake: there is no valid/ready pair. i_id_valid qualifies the decode
// inputs. i_stall holds every register for that edge. i_flush takes priority
// over i_stall and loads a bubble. Outputs change only on a rising i_clk or
// on reset, so no combinational path runs from any input to any output.
//
// Ports:
//   i_clk, i_reset (async, active low)
//   i_id_*              decode-stage instruction fields and register reads
//   i_exm_*, i_mwb_*    producers in EX/MEM and MEM/WB, used for forwarding
//   i_stall, i_flush    hazard-unit controls
//   o_ex_*, o_alu_*     registered execute-stage controls and operands
//   o_ex_rt_fwd         registered forwarded rt (store data)
//   o_bubble_cnt        saturating count of flush-induced bubbles
// -----------------------------------------------------------------------------
module id_ex_operand_stage #(
   parameter int DW = 32,
   parameter int AW = 5,
   parameter int CW = 16
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_id_valid,
   input  logic [AW-1:0] i_id_rs_addr,
   input  logic [AW-1:0] i_id_rt_addr,
   input  logic [DW-1:0] i_id_rs_data,
   input  logic [DW-1:0] i_id_rt_data,
   input  logic [DW-1:0] i_id_imm,
   input  logic [4:0]    i_id_shamt,
   input  logic          i_id_alu_src1,
   input  logic          i_id_alu_src2,
   input  logic [5:0]    i_id_alu_fun,
   input  logic [AW-1:0] i_id_dest,
   input  logic          i_id_regwrite,
   input  logic          i_exm_regwrite,
   input  logic [AW-1:0] i_exm_dest,
   input  logic [DW-1:0] i_exm_result,
   input  logic          i_mwb_regwrite,
   input  logic [AW-1:0] i_mwb_dest,
   input  logic [DW-1:0] i_mwb_result,
   input  logic          i_stall,
   input  logic          i_flush,
   output logic          o_ex_valid,
   output logic [DW-1:0] o_alu_a,
   output logic [DW-1:0] o_alu_b,
   output logic [5:0]    o_alu_fun,
   output logic [AW-1:0] o_ex_dest,
   output logic          o_ex_regwrite,
   output logic [DW-1:0] o_ex_rt_fwd,
   output logic [CW-1:0] o_bubble_cnt
);

   logic [DW-1:0] w_fwd_rs;
   logic [DW-1:0] w_fwd_rt;
   logic [DW-1:0] w_sel_a;
   logic [DW-1:0] w_sel_b;

   logic          r_ex_valid;
   logic [DW-1:0] r_alu_a;
   logic [DW-1:0] r_alu_b;
   logic [5:0]    r_alu_fun;
   logic [AW-1:0] r_ex_dest;
   logic          r_ex_regwrite;
   logic [DW-1:0] r_ex_rt_fwd;
   logic [CW-1:0] r_bubble_cnt;

   // Register 0 is hard-wired to zero, so it is never forwarded. EX/MEM is
   // the younger producer and therefore wins over MEM/WB.
   always_comb begin
      w_fwd_rs = i_id_rs_data;
      if (i_id_rs_addr != '0) begin
         if (i_exm_regwrite && (i_exm_dest == i_id_rs_addr))
            w_fwd_rs = i_exm_result;
         else if (i_mwb_regwrite && (i_mwb_dest == i_id_rs_addr))
            w_fwd_rs = i_mwb_result;
      end
   end

   always_comb begin
      w_fwd_rt = i_id_rt_data;
      if (i_id_rt_addr != '0) begin
         if (i_exm_regwrite && (i_exm_dest == i_id_rt_addr))
            w_fwd_rt = i_exm_result;
         else if (i_mwb_regwrite && (i_mwb_dest == i_id_rt_addr))
            w_fwd_rt = i_mwb_result;
      end
   end

   assign w_sel_a = i_id_alu_src1 ? {{(DW-5){1'b0}}, i_id_shamt} : w_fwd_rs;
   assign w_sel_b = i_id_alu_src2 ? i_id_imm : w_fwd_rt;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_ex_valid    <= 1'b0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_fun     <= '0;
         r_ex_dest     <= '0;
         r_ex_regwrite <= 1'b0;
         r_ex_rt_fwd   <= '0;
         r_bubble_cnt  <= '0;
      end else if (i_flush) begin
         r_ex_valid    <= 1'b0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_fun     <= '0;
         r_ex_dest     <= '0;
         r_ex_regwrite <= 1'b0;
         r_ex_rt_fwd   <= '0;
         // Sticky at all-ones so a long flush storm still reads as "many".
         if (r_bubble_cnt != '1)
            r_bubble_cnt <= r_bubble_cnt + CW'(1);
      end else if (!i_stall) begin
         r_ex_valid    <= i_id_valid;
         r_alu_a       <= w_sel_a;
         r_alu_b       <= w_sel_b;
         r_alu_fun     <= i_id_alu_fun;
         r_ex_dest     <= i_id_dest;
         r_ex_regwrite <= i_id_regwrite & i_id_valid;
         r_ex_rt_fwd   <= w_fwd_rt;
      end
      // Stall without flush: every register holds. Operands are not
      // re-forwarded because producers cannot retire during a stall.
   end

   assign o_ex_valid    = r_ex_valid;
   assign o_alu_a       = r_alu_a;
   assign o_alu_b       = r_alu_b;
   assign o_alu_fun     = r_alu_fun;
   assign o_ex_dest     = r_ex_dest;
   assign o_ex_regwrite = r_ex_regwrite;
   assign o_ex_rt_fwd   = r_ex_rt_fwd;
   assign o_bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_operand_stage
//
// Directed bench for id_ex_operand_stage, instantiated with CW=4 so that
// counter saturation can be reached quickly. Inputs change 1 time unit after
// each rising edge. Outputs are sampled 1 time unit after the edge that
// loads them.
// -----------------------------------------------------------------------------
module tb_id_ex_operand_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;
   localparam logic [5:0] FUN_SRA = 6'h03;
   localparam logic [5:0] FUN_ADD = 6'h20;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic          id_valid, id_alu_src1, id_alu_src2, id_regwrite;
   logic [AW-1:0] id_rs_addr, id_rt_addr, id_dest;
   logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
   logic [4:0]    id_shamt;
   logic [5:0]    id_alu_fun;
   logic          exm_regwrite, mwb_regwrite;
   logic [AW-1:0] exm_dest, mwb_dest;
   logic [DW-1:0] exm_result, mwb_result;
   logic          stall, flush;

   logic          ex_valid, ex_regwrite;
   logic [DW-1:0] alu_a, alu_b, ex_rt_fwd;
   logic [5:0]    alu_fun;
   logic [AW-1:0] ex_dest;
   logic [CW-1:0] bubble_cnt;

   int checks = 0;
   int errors = 0;

   id_ex_operand_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_id_valid(id_valid), .i_id_rs_addr(id_rs_addr), .i_id_rt_addr(id_rt_addr),
      .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data), .i_id_imm(id_imm),
      .i_id_shamt(id_shamt), .i_id_alu_src1(id_alu_src1), .i_id_alu_src2(id_alu_src2),
      .i_id_alu_fun(id_alu_fun), .i_id_dest(id_dest), .i_id_regwrite(id_regwrite),
      .i_exm_regwrite(exm_regwrite), .i_exm_dest(exm_dest), .i_exm_result(exm_result),
      .i_mwb_regwrite(mwb_regwrite), .i_mwb_dest(mwb_dest), .i_mwb_result(mwb_result),
      .i_stall(stall), .i_flush(flush),
      .o_ex_valid(ex_valid), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_fun(alu_fun),
      .o_ex_dest(ex_dest), .o_ex_regwrite(ex_regwrite), .o_ex_rt_fwd(ex_rt_fwd),
      .o_bubble_cnt(bubble_cnt)
   );

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      id_valid = 1'b0; id_rs_addr = '0; id_rt_addr = '0;
      id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_shamt = '0;
      id_alu_src1 = 1'b0; id_alu_src2 = 1'b0; id_alu_fun = '0;
      id_dest = '0; id_regwrite = 1'b0;
      exm_regwrite = 1'b0; exm_dest = '0; exm_result = '0;
      mwb_regwrite = 1'b0; mwb_dest = '0; mwb_result = '0;
      stall = 1'b0; flush = 1'b0;
   endtask

   task automatic drive_random();
      id_valid = 1'($urandom); id_rs_addr = AW'($urandom); id_rt_addr = AW'($urandom);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_shamt = 5'($urandom); id_alu_src1 = 1'($urandom); id_alu_src2 = 1'($urandom);
      id_alu_fun = 6'($urandom); id_dest = AW'($urandom); id_regwrite = 1'($urandom);
      exm_regwrite = 1'($urandom); exm_dest = AW'($urandom); exm_result = $urandom;
      mwb_regwrite = 1'($urandom); mwb_dest = AW'($urandom); mwb_result = $urandom;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [127:0] w_all;
      drive_idle();
      step();
      reset = 1'b1;
      // Load something non-zero so reset has work to do.
      drive_random();
      id_valid = 1'b1; id_alu_src1 = 1'b0; id_rs_addr = 5'd3;
      exm_regwrite = 1'b0; mwb_regwrite = 1'b0; id_rs_data = 32'hDEAD_BEEF;
      step();
      checks++;
      if (alu_a !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL reset_preload: alu_a=%h expected=%h", alu_a, 32'hDEAD_BEEF);
      end
      #2 reset = 1'b0;   // mid-cycle, no clock edge involved
      #1;
      w_all = {ex_valid, alu_a, alu_b, alu_fun, ex_dest, ex_regwrite, ex_rt_fwd, bubble_cnt};
      checks++;
      if (w_all !== '0) begin
         errors++; $display("FAIL reset_async: outputs=%h expected=0", w_all);
      end
      for (int i = 0; i < 3; i++) begin
         drive_random();
         stall = 1'($urandom); flush = 1'($urandom);
         step();
      end
      w_all = {ex_valid, alu_a, alu_b, alu_fun, ex_dest, ex_regwrite, ex_rt_fwd, bubble_cnt};
      checks++;
      if (w_all !== '0) begin
         errors++; $display("FAIL reset_held: outputs=%h expected=0", w_all);
      end
      drive_idle();
      reset = 1'b1;
      id_valid = 1'b1; id_rs_addr = 5'd3; id_rs_data = 32'h11;
      id_rt_addr = 5'd4; id_rt_data = 32'h22; id_alu_fun = 6'h00;
      step();
      checks++;
      if (alu_a !== 32'h11 || alu_b !== 32'h22 || ex_valid !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_load: a=%h b=%h v=%b expected a=11 b=22 v=1", alu_a, alu_b, ex_valid);
      end
   endtask

   task automatic test_forward_priority();
      drive_idle();
      id_valid = 1'b1; id_rs_addr = 5'd8; id_rs_data = 32'h0000_0001;
      id_rt_addr = 5'd8; id_rt_data = 32'h0000_0002;
      exm_regwrite = 1'b1; exm_dest = 5'd8; exm_result = 32'hAAAA_0000;
      mwb_regwrite = 1'b1; mwb_dest = 5'd8; mwb_result = 32'h0000_5555;
      step();
      checks++;
      if (alu_a !== 32'hAAAA_0000 || alu_b !== 32'hAAAA_0000) begin
         errors++; $display("FAIL fwd_exm_wins: a=%h b=%h expected AAAA0000", alu_a, alu_b);
      end
      exm_regwrite = 1'b0;
      step();
      checks++;
      if (alu_a !== 32'h0000_5555 || ex_rt_fwd !== 32'h0000_5555) begin
         errors++; $display("FAIL fwd_mwb: a=%h rtfwd=%h expected 00005555", alu_a, ex_rt_fwd);
      end
      mwb_regwrite = 1'b0;
      step();
      checks++;
      if (alu_a !== 32'h1 || alu_b !== 32'h2) begin
         errors++; $display("FAIL fwd_none: a=%h b=%h expected 1 2", alu_a, alu_b);
      end
      id_rs_addr = 5'd0; id_rs_data = 32'h77;
      exm_regwrite = 1'b1; exm_dest = 5'd0; exm_result = 32'hFFFF_FFFF;
      mwb_regwrite = 1'b1; mwb_dest = 5'd0; mwb_result = 32'hEEEE_EEEE;
      step();
      checks++;
      if (alu_a !== 32'h77) begin
         errors++; $display("FAIL fwd_r0: a=%h expected 77", alu_a);
      end
   endtask

   task automatic test_shift();
      logic [DW-1:0] w_res;
      drive_idle();
      id_valid = 1'b1; id_alu_src1 = 1'b1; id_shamt = 5'd4;
      id_rs_addr = 5'd2; id_rs_data = 32'h1234_5678;
      id_rt_addr = 5'd9; id_rt_data = 32'h0000_0001;
      mwb_regwrite = 1'b1; mwb_dest = 5'd9; mwb_result = 32'h8000_0000;
      id_alu_fun = FUN_SRA; id_dest = 5'd10; id_regwrite = 1'b1;
      step();
      checks++;
      if (alu_a !== 32'h4 || alu_b !== 32'h8000_0000 || alu_fun !== FUN_SRA) begin
         errors++;
         $display("FAIL shift_operands: a=%h b=%h fun=%h expected 4 80000000 03", alu_a, alu_b, alu_fun);
      end
      w_res = $unsigned($signed(alu_b) >>> alu_a[4:0]);
      checks++;
      if (w_res !== 32'hF800_0000 || ex_dest !== 5'd10 || ex_regwrite !== 1'b1) begin
         errors++;
         $display("FAIL shift_result: res=%h dest=%0d we=%b expected F8000000 10 1", w_res, ex_dest, ex_regwrite);
      end
   endtask

   task automatic test_immediate();
      drive_idle();
      id_valid = 1'b1; id_alu_src2 = 1'b1; id_imm = 32'hFFFF_FFF0;
      id_rs_addr = 5'd6; id_rs_data = 32'h1;
      id_rt_addr = 5'd6; id_rt_data = 32'h1;
      exm_regwrite = 1'b1; exm_dest = 5'd6; exm_result = 32'hCAFE_BABE;
      id_alu_fun = FUN_ADD;
      step();
      checks++;
      if (alu_b !== 32'hFFFF_FFF0 || ex_rt_fwd !== 32'hCAFE_BABE || alu_a !== 32'hCAFE_BABE) begin
         errors++;
         $display("FAIL imm_path: a=%h b=%h rtfwd=%h expected CAFEBABE FFFFFFF0 CAFEBABE", alu_a, alu_b, ex_rt_fwd);
      end
   endtask

   task automatic test_stall_flush();
      drive_idle();
      id_valid = 1'b1; id_rs_addr = 5'd5; id_rs_data = 32'h1234;
      id_rt_addr = 5'd7; id_rt_data = 32'h5678; id_alu_fun = FUN_ADD;
      id_dest = 5'd7; id_regwrite = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         stall = 1'b1;
         id_rs_data = 32'h9999_0000 + i; id_alu_fun = 6'h2A; id_dest = 5'd1;
         exm_regwrite = 1'b1; exm_dest = 5'd5; exm_result = 32'hBAD0_0000 + i;
         step();
         checks++;
         if (alu_a !== 32'h1234 || alu_b !== 32'h5678 || alu_fun !== FUN_ADD ||
             ex_dest !== 5'd7 || ex_valid !== 1'b1 || ex_regwrite !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold[%0d]: a=%h b=%h fun=%h dest=%0d v=%b we=%b expected 1234 5678 20 7 1 1",
                     i, alu_a, alu_b, alu_fun, ex_dest, ex_valid, ex_regwrite);
         end
      end
      stall = 1'b1; flush = 1'b1;
      step();
      checks++;
      if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || alu_a !== '0 || alu_b !== '0 ||
          alu_fun !== '0 || ex_dest !== '0 || ex_rt_fwd !== '0 || bubble_cnt !== 4'd1) begin
         errors++;
         $display("FAIL stall_flush_bubble: v=%b we=%b a=%h b=%h fun=%h cnt=%0d expected all 0 cnt=1",
                  ex_valid, ex_regwrite, alu_a, alu_b, alu_fun, bubble_cnt);
      end
   endtask

   task automatic test_idle_bubble();
      drive_idle();
      id_valid = 1'b0; id_regwrite = 1'b1; id_dest = 5'd3;
      id_rs_addr = 5'd3; id_rs_data = 32'h42;
      step();
      checks++;
      if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || bubble_cnt !== 4'd1) begin
         errors++;
         $display("FAIL idle_bubble: v=%b we=%b cnt=%0d expected 0 0 1", ex_valid, ex_regwrite, bubble_cnt);
      end
   endtask

   task automatic test_saturation();
      drive_idle();
      flush = 1'b1;
      // Count is 1 on entry; 13 more flushes reach 14, one more reaches 15.
      for (int i = 0; i < 13; i++) step();
      checks++;
      if (bubble_cnt !== 4'd14) begin
         errors++; $display("FAIL sat_count: cnt=%0d expected 14", bubble_cnt);
      end
      for (int i = 0; i < 20; i++) step();
      checks++;
      if (bubble_cnt !== 4'd15) begin
         errors++; $display("FAIL sat_sticky: cnt=%0d expected 15", bubble_cnt);
      end
      flush = 1'b0;
      step();
      reset = 1'b0;
      #1;
      checks++;
      if (bubble_cnt !== 4'd0) begin
         errors++; $display("FAIL sat_reset: cnt=%0d expected 0", bubble_cnt);
      end
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset_mid_stall();
      drive_idle();
      id_valid = 1'b1; id_rs_addr = 5'd12; id_rs_data = 32'hABCD;
      step();
      stall = 1'b1; flush = 1'b1;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (alu_a !== '0 || ex_valid !== 1'b0 || bubble_cnt !== '0) begin
         errors++;
         $display("FAIL reset_mid_stall: a=%h v=%b cnt=%0d expected 0 0 0", alu_a, ex_valid, bubble_cnt);
      end
      step();
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      id_rs_data = 32'h00C0_FFEE;
      step();
      checks++;
      if (alu_a !== 32'h00C0_FFEE || ex_valid !== 1'b1 || bubble_cnt !== '0) begin
         errors++;
         $display("FAIL reset_release_load: a=%h v=%b cnt=%0d expected 00C0FFEE 1 0", alu_a, ex_valid, bubble_cnt);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_forward_priority();
      test_shift();
      test_immediate();
      test_stall_flush();
      test_idle_bubble();
      test_saturation();
      test_reset_mid_stall();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded 100000 time units");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview: ID/EX pipeline register that selects, forwards and registers the two ALU operands and the 6-bit ALU function code for the execute stage. Outputs alu_a/alu_b/alu_fun drive the ALU directly, shift unit included. For shifts, alu_b carries the value to shift and alu_a[4:0] the shift amount. Handles stall (hold) and flush (bubble), resolves EX/MEM and MEM/WB forwarding, and counts inserted bubbles for debug.

Parameters:
DW, 32, datapath width
AW, 5, register-address width
CW, 16, bubble-counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  decode stage holds a valid instruction
id_rs_addr  in  AW  source register rs
id_rt_addr  in  AW  source register rt
id_rs_data  in  DW  register-file read of rs
id_rt_data  in  DW  register-file read of rt
id_imm  in  DW  extended immediate
id_shamt  in  5  instruction shamt field
id_alu_src1  in  1  1: operand A = zero-extended shamt (sll/srl/sra)
id_alu_src2  in  1  1: operand B = id_imm
id_alu_fun  in  6  ALU function code
id_dest  in  AW  destination register
id_regwrite  in  1  instruction writes the register file
exm_regwrite  in  1  EX/MEM instruction writes back
exm_dest  in  AW  EX/MEM destination
exm_result  in  DW  EX/MEM ALU result
mwb_regwrite  in  1  MEM/WB instruction writes back
mwb_dest  in  AW  MEM/WB destination
mwb_result  in  DW  MEM/WB write-back data
stall  in  1  hold stage contents
flush  in  1  replace stage contents with a bubble
ex_valid  out  1  registered valid
alu_a  out  DW  registered operand A
alu_b  out  DW  registered operand B
alu_fun  out  6  registered function code
ex_dest  out  AW  registered destination
ex_regwrite  out  1  registered write-enable, qualified by valid
ex_rt_fwd  out  DW  registered forwarded rt, for store data
bubble_cnt  out  CW  saturating count of flush-induced bubbles

Behaviour:
- Reset (reset=0, async): all outputs 0; takes effect immediately, independent of clk.
- Forwarding (combinational, before the register), per source s in {rs, rt}:
  - s_addr==0 never forwards; the value is id_s_data (expected 0).
  - Else if exm_regwrite and exm_dest==s_addr, use exm_result (highest priority).
  - Else if mwb_regwrite and mwb_dest==s_addr, use mwb_result.
  - Else use id_s_data.
- Operand select:
  - A = id_alu_src1 ? {27'b0, id_shamt} : fwd_rs.
  - B = id_alu_src2 ? id_imm : fwd_rt.
  - ex_rt_fwd = fwd_rt always.
- Update each rising clk, priority flush > stall > load:
  - flush=1: ex_valid=0, ex_regwrite=0, alu_fun=0, alu_a=alu_b=ex_rt_fwd=0, ex_dest=0; bubble_cnt+=1, saturating at all-ones.
  - stall=1, flush=0: every register holds, including operands, which are not re-forwarded. The hazard unit guarantees that producers do not retire while a stall holds this stage.
  - Otherwise: load the selected values. ex_valid=id_valid; ex_regwrite=id_regwrite & id_valid.
- Latency: exactly 1 cycle from ID inputs to EX outputs. No combinational path from any input to any output.
- id_valid=0 with no stall or flush loads a bubble, but does not increment bubble_cnt.
- bubble_cnt clears only on reset. It is sticky at saturation (2^CW-1).
- Reset asserted mid-stall or mid-flush: reset wins. After release, the first edge loads normally.

Test Plan:
- Reset: reset=0 with random inputs toggling -> all outputs 0 with no clk edge; release, load rs=3 (data 0x11), rt=4 (data 0x22), alu_fun=0x00 -> next edge alu_a=0x11, alu_b=0x22.
- Forward priority: rs=8, exm(8, 0xAAAA0000), mwb(8, 0x5555) both writing -> alu_a=0xAAAA0000; exm_regwrite=0 -> alu_a=0x5555; rs=0 with exm_dest=0 -> alu_a=id_rs_data.
- Shift operands: sra with id_alu_src1=1, shamt=4, rt forwarded from mwb=0x80000000 -> alu_a=0x00000004, alu_b=0x80000000, alu_fun=sra code; the ALU result is then 0xF8000000.
- Stall/flush: load 0x1234, stall 3 cycles while inputs change -> outputs remain 0x1234; stall+flush together -> bubble (ex_valid=0, ex_regwrite=0), bubble_cnt=1.
- Immediate path: id_alu_src2=1, imm=0xFFFFFFF0, rt forwarded -> alu_b=0xFFFFFFF0, ex_rt_fwd=forwarded rt.
- Counter saturation: CW=4, 20 consecutive flushes -> bubble_cnt stops at 15; then reset=0 -> 0.
